call_stack: RTL

CALL_STACK -- requirements
Module: call_stack

---
 rtl/call_stack.sv | 110 +++++++++++
 1 files changed

// File: rtl/call_stack.sv
// Hardware return-address stack for CALL/RET: push stores pc+1, pop drives the
// top entry onto the bus one cycle later with a single-cycle output enable.
module call_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         pc,
   input  logic                     c_stk_push,
   input  logic                     c_stk_pop,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_oe,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0]    count_q, count_d, count_m1;
   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic             bus_oe_q, bus_oe_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] ret_addr;

   assign ret_addr = pc + WIDTH'(1);
   assign count_m1 = count_q - CW'(1);
   assign top_idx  = count_m1[AW-1:0];

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      count_d     = count_q;
      bus_out_d   = '0;
      bus_oe_d    = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      we          = 1'b0;
      waddr       = count_q[AW-1:0];

      if (c_stk_push && c_stk_pop) begin
         bus_oe_d = 1'b1;
         if (empty) begin
            // Nothing stored: the pushed address goes straight back out.
            bus_out_d = ret_addr;
         end else begin
            bus_out_d = mem[top_idx];
            we        = 1'b1;
            waddr     = top_idx;
         end
      end else if (c_stk_push) begin
         if (full) begin
            overflow_d = 1'b1;
         end else begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
         end
      end else if (c_stk_pop) begin
         if (empty) begin
            underflow_d = 1'b1;
         end else begin
            bus_out_d = mem[top_idx];
            bus_oe_d  = 1'b1;
            count_d   = count_m1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q     <= '0;
         bus_out_q   <= '0;
         bus_oe_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         bus_out_q   <= bus_out_d;
         bus_oe_q    <= bus_oe_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Entries are never cleared; count alone defines which are valid.
   always_ff @(posedge clk) begin
      if (reset && we) begin
         mem[waddr] <= ret_addr;
      end
   end

   assign bus_out   = bus_out_q;
   assign bus_oe    = bus_oe_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
